alu_op_sequencer: RTL



---
 rtl/alu_op_sequencer_if.sv | 70 +++++++
 rtl/alu_op_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle between the ALU op sequencer and its scheduler, consumer and ALU.
// Optional flag outputs appear when ALU_OP_SEQUENCER_FLAGS_EN is defined.
interface alu_op_sequencer_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [3:0]  req_cmd_in;
  logic [7:0]  req_a_in;
  logic [7:0]  req_b_in;
  logic [7:0]  alu_a_out;
  logic [7:0]  alu_b_out;
  logic [3:0]  alu_command_out;
  logic        alu_oe_out;
  logic [15:0] alu_d_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [15:0] rsp_data_out;
  logic [3:0]  rsp_cmd_out;
  logic [15:0] ops_count_out;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
  logic        rsp_zero_out;
  logic        rsp_carry_out;
  logic        rsp_borrow_out;
`endif

  modport master (
    input  req_valid_in,
    input  req_cmd_in,
    input  req_a_in,
    input  req_b_in,
    input  alu_d_in,
    input  rsp_ready_in,
    output req_ready_out,
    output alu_a_out,
    output alu_b_out,
    output alu_command_out,
    output alu_oe_out,
    output rsp_valid_out,
    output rsp_data_out,
    output rsp_cmd_out,
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    output rsp_zero_out,
    output rsp_carry_out,
    output rsp_borrow_out,
`endif
    output ops_count_out
  );

  modport slave (
    output req_valid_in,
    output req_cmd_in,
    output req_a_in,
    output req_b_in,
    output alu_d_in,
    output rsp_ready_in,
    input  req_ready_out,
    input  alu_a_out,
    input  alu_b_out,
    input  alu_command_out,
    input  alu_oe_out,
    input  rsp_valid_out,
    input  rsp_data_out,
    input  rsp_cmd_out,
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    input  rsp_zero_out,
    input  rsp_carry_out,
    input  rsp_borrow_out,
`endif
    input  ops_count_out
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator for the 8-bit combinational ALU: request -> setup -> settle -> response.
// Define ALU_OP_SEQUENCER_FLAGS_EN to add zero/carry/borrow response flags.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic                clk,
  input logic                rst,
  alu_op_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SETTLE,
    RESP
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  localparam logic [3:0] C_ADD = 4'h0;
  localparam logic [3:0] C_INC = 4'h1;
  localparam logic [3:0] C_SUB = 4'h2;
  localparam logic [3:0] C_DEC = 4'h3;
  localparam logic [3:0] C_SHL = 4'h6;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [7:0]  a_q;
  logic [7:0]  a_nxt;
  logic [7:0]  b_q;
  logic [7:0]  b_nxt;
  logic [3:0]  cmd_q;
  logic [3:0]  cmd_nxt;
  logic        oe_q;
  logic        oe_nxt;
  logic        valid_q;
  logic        valid_nxt;
  logic [15:0] data_q;
  logic [15:0] data_nxt;
  logic [3:0]  rcmd_q;
  logic [3:0]  rcmd_nxt;
  logic [15:0] ops_q;
  logic [15:0] ops_nxt;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
  logic        zero_q;
  logic        zero_nxt;
  logic        carry_q;
  logic        carry_nxt;
  logic        borrow_q;
  logic        borrow_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a_q;
    b_nxt     = b_q;
    cmd_nxt   = cmd_q;
    oe_nxt    = oe_q;
    valid_nxt = valid_q;
    data_nxt  = data_q;
    rcmd_nxt  = rcmd_q;
    ops_nxt   = ops_q;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    zero_nxt   = zero_q;
    carry_nxt  = carry_q;
    borrow_nxt = borrow_q;
`endif
    unique case (state)
      IDLE: begin
        if (bus.req_valid_in) begin
          a_nxt     = bus.req_a_in;
          b_nxt     = bus.req_b_in;
          cmd_nxt   = bus.req_cmd_in;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        oe_nxt    = 1'b1;
        cnt_nxt   = 4'd0;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == LAST) begin
          data_nxt  = bus.alu_d_in;
          rcmd_nxt  = cmd_q;
          oe_nxt    = 1'b0;
          valid_nxt = 1'b1;
          state_nxt = RESP;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
          zero_nxt   = (bus.alu_d_in == 16'h0000);
          carry_nxt  = (cmd_q == C_ADD || cmd_q == C_INC ||
                        cmd_q == C_SHL) && bus.alu_d_in[8];
          borrow_nxt = (cmd_q == C_SUB || cmd_q == C_DEC) &&
                       bus.alu_d_in[15];
`endif
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_in) begin
          valid_nxt = 1'b0;
          ops_nxt   = ops_q + 16'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cmd_q   <= 4'h0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
      rcmd_q  <= 4'h0;
      ops_q   <= 16'h0000;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      cmd_q   <= cmd_nxt;
      oe_q    <= oe_nxt;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
      rcmd_q  <= rcmd_nxt;
      ops_q   <= ops_nxt;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
      zero_q   <= zero_nxt;
      carry_q  <= carry_nxt;
      borrow_q <= borrow_nxt;
`endif
    end
  end

  // Ready is the only decoded output; held low while reset is asserted.
  assign bus.req_ready_out   = (state == IDLE) && !rst;
  assign bus.alu_a_out       = a_q;
  assign bus.alu_b_out       = b_q;
  assign bus.alu_command_out = cmd_q;
  assign bus.alu_oe_out      = oe_q;
  assign bus.rsp_valid_out   = valid_q;
  assign bus.rsp_data_out    = data_q;
  assign bus.rsp_cmd_out     = rcmd_q;
  assign bus.ops_count_out   = ops_q;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
  assign bus.rsp_zero_out    = zero_q;
  assign bus.rsp_carry_out   = carry_q;
  assign bus.rsp_borrow_out  = borrow_q;
`endif

endmodule
